uart_tx_sequencer: RTL

Bus-side controller for the PC16550D-compatible UART. Out of reset it programs the UART (divisor, line control, FIFO control, interrupt enable) through the UART's 8-bit register port. It then shares the transmitter between two byte requesters and sequences each transfer as an LSR poll for THRE followed by a THR write. It sits between internal producers (e.g. debug/console streams) and the UART's A/Din/Dout/MEMRb/MEMWb port.

---
 rtl/uart_tx_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_sequencer.sv
// Programs a 16550 UART out of reset, then arbitrates two byte requesters onto its THR.
// Define UART_TX_SEQ_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module uart_tx_sequencer #(
    parameter logic [15:0] DIVISOR    = 16'd1,
    parameter logic [7:0]  LCR_VAL    = 8'h03,
    parameter logic [7:0]  FCR_VAL    = 8'h01,
    parameter logic [7:0]  IER_VAL    = 8'h00,
    parameter logic [15:0] POLL_LIMIT = 16'd1024
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic [1:0]  ReqValid,
    input  logic [15:0] ReqData,
    output logic [1:0]  ReqReady,
    output logic [2:0]  UartA,
    output logic [7:0]  UartDin,
    input  logic [7:0]  UartDout,
    output logic        UartMEMRb,
    output logic        UartMEMWb,
    output logic        InitDone,
    output logic        Busy,
    output logic        Timeout
);

    typedef enum logic [3:0] {
        INIT_LCRD,
        INIT_DLL,
        INIT_DLM,
        INIT_LCR,
        INIT_FCR,
        INIT_IER,
        IDLE,
        POLL,
        WRITE
    } state_t;

    state_t      state;
    logic [7:0]  tx_byte;
    logic        last_grant;
    logic [15:0] poll_cnt;
    logic [1:0]  grant;
    logic [2:0]  bus_a;
    logic [7:0]  bus_din;
    logic        bus_rb;
    logic        bus_wb;
    logic        thre;
    logic        dout_unused;

    assign thre        = UartDout[5];
    assign dout_unused = ^{UartDout[7:6], UartDout[4:0]};

    always_comb begin
        grant = 2'b00;
        if (state == IDLE) begin
`ifdef UART_TX_SEQ_RR_EN
            case (ReqValid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
`else
            if (ReqValid[0])
                grant = 2'b01;
            else if (ReqValid[1])
                grant = 2'b10;
`endif
        end
    end

    always_comb begin
        bus_a   = 3'd0;
        bus_din = 8'h00;
        bus_rb  = 1'b1;
        bus_wb  = 1'b1;
        case (state)
            INIT_LCRD: begin bus_a = 3'd3; bus_din = 8'h80;           bus_wb = 1'b0; end
            INIT_DLL:  begin bus_a = 3'd0; bus_din = DIVISOR[7:0];    bus_wb = 1'b0; end
            INIT_DLM:  begin bus_a = 3'd1; bus_din = DIVISOR[15:8];   bus_wb = 1'b0; end
            INIT_LCR:  begin bus_a = 3'd3; bus_din = {1'b0, LCR_VAL[6:0]}; bus_wb = 1'b0; end
            INIT_FCR:  begin bus_a = 3'd2; bus_din = FCR_VAL;         bus_wb = 1'b0; end
            INIT_IER:  begin bus_a = 3'd1; bus_din = IER_VAL;         bus_wb = 1'b0; end
            POLL:      begin bus_a = 3'd5; bus_rb = 1'b0; end
            WRITE:     begin bus_a = 3'd0; bus_din = tx_byte;         bus_wb = 1'b0; end
            default:   ;
        endcase
    end

    // Reset state is an init write; hold the bus quiet while reset is applied.
    assign UartA     = PRESETn ? bus_a : 3'd0;
    assign UartDin   = PRESETn ? bus_din : 8'h00;
    assign UartMEMRb = bus_rb | ~PRESETn;
    assign UartMEMWb = bus_wb | ~PRESETn;
    assign ReqReady  = grant;
    assign Busy      = (state != IDLE);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state      <= INIT_LCRD;
            tx_byte    <= 8'h00;
            last_grant <= 1'b1;
            poll_cnt   <= 16'd0;
            InitDone   <= 1'b0;
            Timeout    <= 1'b0;
        end else begin
            case (state)
                INIT_LCRD: state <= INIT_DLL;
                INIT_DLL:  state <= INIT_DLM;
                INIT_DLM:  state <= INIT_LCR;
                INIT_LCR:  state <= INIT_FCR;
                INIT_FCR:  state <= INIT_IER;
                INIT_IER: begin
                    state    <= IDLE;
                    InitDone <= 1'b1;
                end
                IDLE: begin
                    if (|grant) begin
                        tx_byte    <= grant[1] ? ReqData[15:8] : ReqData[7:0];
                        last_grant <= grant[1];
                        poll_cnt   <= 16'd0;
                        state      <= POLL;
                    end
                end
                POLL: begin
                    if (thre) begin
                        state <= WRITE;
                    end else if (poll_cnt == POLL_LIMIT - 16'd1) begin
                        Timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        poll_cnt <= poll_cnt + 16'd1;
                    end
                end
                WRITE:   state <= IDLE;
                default: state <= INIT_LCRD;
            endcase
        end
    end

endmodule
